// File: rtl/bit8_1to3_demux_buf.sv
// bit8_1to3_demux_buf: buffered 1-to-3 demux, each channel a 2-entry valid/ready FIFO with a registered head
module bit8_1to3_demux_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             sel1,
   input  logic             sel2,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [WIDTH-1:0] out3,
   output logic             out3_valid,
   input  logic             out3_ready
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   logic [2:0] selv, rdy, full, push;
   assign selv = sel1 ? 3'b100 : sel2 ? 3'b010 : 3'b001;
   assign rdy = {out3_ready, out2_ready, out1_ready};
   assign full = {g_ch[2].st == FULL, g_ch[1].st == FULL, g_ch[0].st == FULL};
   assign in_ready = !reset && |(selv & (~full | rdy));
   assign push = (in_valid && in_ready) ? selv : 3'b000;
   for (genvar i = 0; i < 3; i++) begin : g_ch
      state_t st, st_n;
      logic rp, rp_n, wp, pop;
      logic [1:0][WIDTH-1:0] mem, mem_n;
      logic [WIDTH-1:0] hd, hd_n;
      assign pop = (st != EMPTY) && rdy[i];
      always_comb begin
         st_n = st;
         if (push[i] && !pop) st_n = (st == EMPTY) ? ONE : FULL;
         if (pop && !push[i]) st_n = (st == FULL) ? ONE : EMPTY;
         wp = rp ^ (st == ONE);
         rp_n = rp ^ pop;
         mem_n = mem;
         if (push[i]) mem_n[wp] = in;
         hd_n = (st_n != EMPTY) ? mem_n[rp_n] : hd;
      end
      always_ff @(posedge clk) begin
         if (reset) begin
            st <= EMPTY;
            rp <= 1'b0;
            mem <= '0;
            hd <= '0;
         end else begin
            st <= st_n;
            rp <= rp_n;
            mem <= mem_n;
            hd <= hd_n;
         end
      end
   end
   assign out1 = g_ch[0].hd;
   assign out2 = g_ch[1].hd;
   assign out3 = g_ch[2].hd;
   assign out1_valid = g_ch[0].st != EMPTY;
   assign out2_valid = g_ch[1].st != EMPTY;
   assign out3_valid = g_ch[2].st != EMPTY;
endmodule

// File: tb/tb_bit8_1to3_demux_buf.sv
// tb_bit8_1to3_demux_buf: directed scenarios plus a scoreboarded random stream for the buffered 1-to-3 demux
module tb_bit8_1to3_demux_buf;
   logic clk = 0, reset = 1, sel1 = 0, sel2 = 0, in_valid = 0, in_ready;
   logic [7:0] in = 0, out1, out2, out3;
   logic out1_valid, out2_valid, out3_valid;
   logic out1_ready = 0, out2_ready = 0, out3_ready = 0;
   int n_cmp = 0, n_bad = 0;
   bit8_1to3_demux_buf #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .in(in), .sel1(sel1), .sel2(sel2),
      .in_valid(in_valid), .in_ready(in_ready),
      .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .out2(out2), .out2_valid(out2_valid), .out2_ready(out2_ready),
      .out3(out3), .out3_valid(out3_valid), .out3_ready(out3_ready)
   );
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] s, input logic [7:0] d);
      {sel1, sel2} = s;
      in = d;
      in_valid = 1;
   endtask

   task automatic test_reset;
      reset = 1;
      drive(2'b00, 8'hFF);
      step;
      step;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if ({out1_valid, out2_valid, out3_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_valid: got %b want 000", {out1_valid, out2_valid, out3_valid}); end
      n_cmp++; if ({out1, out2, out3} !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h want 000000", {out1, out2, out3}); end
      reset = 0;
      in_valid = 0;
   endtask

   task automatic test_single;
      drive(2'b00, 8'hA5);
      out1_ready = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
      step;
      in_valid = 0;
      n_cmp++; if (out1 !== 8'hA5 || out1_valid !== 1'b1) begin n_bad++; $display("FAIL single_out1: got %h/%b want a5/1", out1, out1_valid); end
      n_cmp++; if ({out2_valid, out3_valid} !== 2'b00) begin n_bad++; $display("FAIL single_others: got %b want 00", {out2_valid, out3_valid}); end
      step;
      n_cmp++; if (out1_valid !== 1'b0 || out1 !== 8'hA5) begin n_bad++; $display("FAIL single_drained: got %h/%b want a5/0", out1, out1_valid); end
      out1_ready = 0;
   endtask

   task automatic test_stall;
      drive(2'b01, 8'h11);
      step;
      drive(2'b01, 8'h22);
      step;
      drive(2'b01, 8'h33);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_full_ready: got %b want 0", in_ready); end
      n_cmp++; if (out2 !== 8'h11 || out2_valid !== 1'b1) begin n_bad++; $display("FAIL stall_head: got %h/%b want 11/1", out2, out2_valid); end
      out2_ready = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_passthru_ready: got %b want 1", in_ready); end
      step;
      in_valid = 0;
      n_cmp++; if (out2 !== 8'h22 || out2_valid !== 1'b1) begin n_bad++; $display("FAIL stall_second: got %h/%b want 22/1", out2, out2_valid); end
      step;
      n_cmp++; if (out2 !== 8'h33 || out2_valid !== 1'b1) begin n_bad++; $display("FAIL stall_third: got %h/%b want 33/1", out2, out2_valid); end
      step;
      n_cmp++; if (out2_valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty: got %b want 0", out2_valid); end
      out2_ready = 0;
   endtask

   task automatic test_cross;
      drive(2'b00, 8'hC1);
      step;
      drive(2'b00, 8'hC2);
      step;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL cross_ch1_full: got %b want 0", in_ready); end
      drive(2'b10, 8'h44);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL cross_ch3_ready: got %b want 1", in_ready); end
      step;
      drive(2'b11, 8'h55);
      step;
      in_valid = 0;
      n_cmp++; if (out3 !== 8'h44 || out3_valid !== 1'b1) begin n_bad++; $display("FAIL cross_out3_first: got %h/%b want 44/1", out3, out3_valid); end
      out3_ready = 1;
      step;
      n_cmp++; if (out3 !== 8'h55 || out3_valid !== 1'b1) begin n_bad++; $display("FAIL cross_out3_second: got %h/%b want 55/1", out3, out3_valid); end
      step;
      n_cmp++; if (out3_valid !== 1'b0) begin n_bad++; $display("FAIL cross_out3_empty: got %b want 0", out3_valid); end
      out3_ready = 0;
      n_cmp++; if (out1 !== 8'hC1 || out1_valid !== 1'b1) begin n_bad++; $display("FAIL cross_ch1_kept: got %h/%b want c1/1", out1, out1_valid); end
      out1_ready = 1;
      step;
      n_cmp++; if (out1 !== 8'hC2 || out1_valid !== 1'b1) begin n_bad++; $display("FAIL cross_ch1_second: got %h/%b want c2/1", out1, out1_valid); end
      step;
      n_cmp++; if (out1_valid !== 1'b0) begin n_bad++; $display("FAIL cross_ch1_empty: got %b want 0", out1_valid); end
      out1_ready = 0;
   endtask

   task automatic test_pushpop_one;
      drive(2'b01, 8'h66);
      step;
      drive(2'b01, 8'h77);
      out2_ready = 1;
      step;
      in_valid = 0;
      out2_ready = 0;
      n_cmp++; if (out2 !== 8'h77 || out2_valid !== 1'b1) begin n_bad++; $display("FAIL pushpop_head: got %h/%b want 77/1", out2, out2_valid); end
      out2_ready = 1;
      step;
      n_cmp++; if (out2_valid !== 1'b0) begin n_bad++; $display("FAIL pushpop_count: got %b want 0", out2_valid); end
      out2_ready = 0;
   endtask

   task automatic test_mid_reset;
      drive(2'b00, 8'hA1); step;
      drive(2'b00, 8'hA2); step;
      drive(2'b01, 8'hB1); step;
      drive(2'b01, 8'hB2); step;
      drive(2'b10, 8'hD1); step;
      drive(2'b10, 8'hD2); step;
      n_cmp++; if ({out1_valid, out2_valid, out3_valid} !== 3'b111) begin n_bad++; $display("FAIL midrst_filled: got %b want 111", {out1_valid, out2_valid, out3_valid}); end
      drive(2'b00, 8'hFF);
      out1_ready = 1;
      reset = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
      step;
      out1_ready = 0;
      n_cmp++; if ({out1_valid, out2_valid, out3_valid} !== 3'b000) begin n_bad++; $display("FAIL midrst_valid: got %b want 000", {out1_valid, out2_valid, out3_valid}); end
      n_cmp++; if ({out1, out2, out3} !== 24'h0) begin n_bad++; $display("FAIL midrst_data: got %h want 000000", {out1, out2, out3}); end
      reset = 0;
      drive(2'b00, 8'h0F);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
      step;
      in_valid = 0;
      n_cmp++; if (out1 !== 8'h0F || out1_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_first: got %h/%b want 0f/1", out1, out1_valid); end
      n_cmp++; if ({out2_valid, out3_valid} !== 2'b00) begin n_bad++; $display("FAIL midrst_others: got %b want 00", {out2_valid, out3_valid}); end
      out1_ready = 1;
      step;
      out1_ready = 0;
   endtask

   task automatic test_random;
      logic [7:0] sb [3][$];
      logic [7:0] o [3];
      logic [2:0] r, v;
      logic [1:0] s;
      logic exp_rdy;
      int ch, acc = 0, cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         s = 2'($urandom_range(0, 3));
         drive(s, 8'($urandom));
         in_valid = ($urandom_range(0, 3) != 0);
         r = 3'($urandom);
         {out3_ready, out2_ready, out1_ready} = r;
         #1;
         ch = s[1] ? 2 : int'(s[0]);
         exp_rdy = sb[ch].size() < 2 || r[ch];
         n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy); end
         v = {sb[2].size() != 0, sb[1].size() != 0, sb[0].size() != 0};
         n_cmp++; if ({out3_valid, out2_valid, out1_valid} !== v) begin n_bad++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, {out3_valid, out2_valid, out1_valid}, v); end
         o[0] = out1; o[1] = out2; o[2] = out3;
         for (int c = 0; c < 3; c++)
            if (v[c]) begin
               n_cmp++; if (o[c] !== sb[c][0]) begin n_bad++; $display("FAIL rand_data ch%0d cyc %0d: got %h want %h", c + 1, cyc, o[c], sb[c][0]); end
            end
         step;
         for (int c = 0; c < 3; c++)
            if (v[c] && r[c]) void'(sb[c].pop_front());
         if (in_valid && exp_rdy) begin
            sb[ch].push_back(in);
            acc++;
         end
         cyc++;
      end
      n_cmp++; if (acc != 1000) begin n_bad++; $display("FAIL rand_timeout: got %0d bytes want 1000", acc); end
      in_valid = 0;
      {out3_ready, out2_ready, out1_ready} = 3'b111;
      for (int k = 0; k < 2; k++) begin
         o[0] = out1; o[1] = out2; o[2] = out3;
         for (int c = 0; c < 3; c++)
            if (sb[c].size() != 0) begin
               n_cmp++; if (o[c] !== sb[c][0]) begin n_bad++; $display("FAIL drain_data ch%0d: got %h want %h", c + 1, o[c], sb[c][0]); end
               void'(sb[c].pop_front());
            end
         step;
      end
      n_cmp++; if ({out3_valid, out2_valid, out1_valid} !== 3'b000) begin n_bad++; $display("FAIL drain_empty: got %b want 000", {out3_valid, out2_valid, out1_valid}); end
      {out3_ready, out2_ready, out1_ready} = 3'b000;
   endtask

   initial begin
      test_reset;
      test_single;
      test_stall;
      test_cross;
      test_pushpop_one;
      test_mid_reset;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bit8_1to3_demux_buf.md
Name: bit8_1to3_demux_buf

Overview:
- Buffered 8-bit 1-to-3 demultiplexer; the distributing counterpart of the team's 8-bit 3:1 mux.
- Routes each accepted input byte to one of three output channels, chosen by sel1/sel2.
- Each channel has a 2-entry FIFO with independent valid/ready, so one stalled consumer does not block the others unless it is the selected target.
- Sits between a single producer (e.g. ALU or bus result) and three consumer blocks.

Parameters:
WIDTH, 8, data width of the input and of each output channel (all widths below are WIDTH).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in  input  WIDTH  input data byte
sel1  input  1  select MSB
sel2  input  1  select LSB
in_valid  input  1  producer presents a byte
in_ready  output  1  block can accept the byte this cycle
out1  output  WIDTH  channel 1 head data
out1_valid  output  1  channel 1 head is valid
out1_ready  input  1  channel 1 consumer accepts head
out2  output  WIDTH  channel 2 head data
out2_valid  output  1  channel 2 head is valid
out2_ready  input  1  channel 2 consumer accepts head
out3  output  WIDTH  channel 3 head data
out3_valid  output  1  channel 3 head is valid
out3_ready  input  1  channel 3 consumer accepts head

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Select encoding matches the 3:1 mux:
  - {sel1,sel2}=00 selects channel 1.
  - 01 selects channel 2.
  - 10 or 11 selects channel 3.
- Select sampling: sel1/sel2 are sampled only in the cycle of an input handshake (in_valid && in_ready). They are don't-care otherwise.
- Per-channel state: 2-entry FIFO (two WIDTH registers), a 2-bit occupancy cnt in {0,1,2}, and a 1-bit read pointer.
- Per-channel states: EMPTY (cnt=0), ONE (cnt=1), FULL (cnt=2).
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only: FULL->ONE, ONE->EMPTY.
  - push and pop together: state unchanged.
- push_N = in_valid && in_ready && channel N selected.
- pop_N = outN_valid && outN_ready.
- outN_valid = (cnt_N != 0), registered.
- outN is the FIFO head entry, registered (no combinational path from in).
- Latency: a byte accepted in cycle T is visible at outN with outN_valid=1 in cycle T+1 if channel N was EMPTY, or behind earlier entries otherwise.
- in_ready is combinational: cnt_sel < 2, OR cnt_sel == 2 && outsel_ready (pop and push in the same cycle). in_ready depends only on the selected channel.
- Boundaries:
  - Push into FULL without a simultaneous pop cannot occur (in_ready=0); the producer holds in and sel.
  - Simultaneous push+pop in ONE: the old head leaves, the new byte becomes head next cycle, cnt stays 1.
  - Simultaneous push+pop in FULL: the second entry becomes head, the new byte is stored behind it, cnt stays 2.
  - outN_ready while EMPTY has no effect.
  - Ordering is FIFO within a channel. There is no ordering guarantee across channels.
  - Non-selected channels keep draining independently during any input stall.
  - When a channel goes EMPTY, outN holds the last popped value; only outN_valid qualifies it.
- Reset (including mid-transfer):
  - Next edge: all cnt=0, read pointers=0, all FIFO registers=0.
  - out1/out2/out3=0, all outN_valid=0.
  - in_ready=0 while reset is high.
  - Buffered bytes are discarded.
  - First handshake is possible in the cycle after reset deasserts.

Test Plan:
- Reset, then in=8'hA5, sel=00, in_valid for 1 cycle, out1_ready=1 -> next cycle out1=A5, out1_valid=1, out2_valid=out3_valid=0; cycle after, out1_valid=0.
- Send 11,22,33 to sel=01 with out2_ready=0 -> 11 and 22 accepted, in_ready=0 on 33. Then out2_ready=1 -> 33 is accepted in the same cycle 11 pops; out2 shows 11, 22, 33 in order.
- Channel 1 FULL with out1_ready=0; send 44 to sel=10 and 55 to sel=11 -> both accepted, out3 shows 44 then 55; channel 1 contents (2 entries) unchanged.
- Channel 2 at cnt=1 (head 66), push 77 with out2_ready=1 in the same cycle -> cnt stays 1, out2=77 next cycle, out2_valid stays 1.
- Fill all three channels (2 entries each), assert reset for 1 cycle mid-stream -> all outN=0, all outN_valid=0, in_ready=0 during reset. After release, 8'h0F to sel=00 -> out1=0F one cycle later.
- Random 1000-byte stream with random sel and random outN_ready -> per-channel scoreboard: no loss, no duplication, per-channel order preserved.
